rbi_mmu_acl_cache: RTL and testbench

Four-entry, fully associative ACL cache for the ringbus MMU. It supplies the four ACL entry buses (A..D) consumed by the MMU access checker, in most-recently-used order. It accepts LDACL inserts and invalidate-all from the control path. When an ACL-enabled TLB access finds no matching entry, it raises a miss request toward the fill/exception path.

---
 rtl/rbi_acl_pkg.sv | 27 ++
 rtl/rbi_acl_slot_match.sv | 30 +++
 rtl/rbi_mmu_acl_cache.sv | 195 +++++++++++++++++++
 tb/tb_rbi_mmu_acl_cache.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbi_acl_pkg.sv
// Shared definitions for the ringbus MMU ACL cache: entry layout, miss FSM
// encoding and the default miss timeout.
package rbi_acl_pkg;

    localparam int unsigned ACL_SLOTS    = 4;
    localparam int unsigned ACL_ENTRY_W  = 48;

    // Entry field offsets
    localparam int unsigned ACL_ID_LSB   = 0;
    localparam int unsigned ACL_ID_MSB   = 15;
    localparam int unsigned ACL_KEY_LSB  = 16;
    localparam int unsigned ACL_KEY_MSB  = 31;
    localparam int unsigned ACL_MODE_LSB = 32;
    localparam int unsigned ACL_MODE_MSB = 43;

    // Cycles spent waiting for a fill before the miss is abandoned
    localparam int unsigned ACL_MISS_TMO_DEFAULT = 255;

    typedef logic [ACL_ENTRY_W-1:0] acl_entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } miss_state_e;

endpackage

// File: rtl/rbi_acl_slot_match.sv
// Compares one ACL slot against the registered lookup ID and the four
// keyring keys. A zero key never matches.
module rbi_acl_slot_match
    import rbi_acl_pkg::*;
(
    input  logic        valid_i,
    input  logic [47:0] entry_i,
    input  logic [15:0] acl_id_i,
    input  logic [63:0] krr_i,
    output logic        hit_o
);

    logic key_hit;
    logic unused_entry;

    assign unused_entry = ^entry_i[ACL_ENTRY_W-1:ACL_MODE_LSB];

    // Slot hits when valid, the ID matches and any nonzero key matches
    always_comb begin
        key_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((krr_i[16*k +: 16] != 16'h0) &&
                (krr_i[16*k +: 16] == entry_i[ACL_KEY_MSB:ACL_KEY_LSB])) begin
                key_hit = 1'b1;
            end
        end
        hit_o = valid_i && (entry_i[ACL_ID_MSB:ACL_ID_LSB] == acl_id_i) && key_hit;
    end

endmodule

// File: rtl/rbi_mmu_acl_cache.sv
// Four-entry fully associative ACL cache for the ringbus MMU.
// Slot A is the most recently inserted (or used) entry.
// Optional feature: define RBI_ACL_HITPROMOTE_EN to move hit entries to A
// (LRU order); otherwise the order is pure insertion order.
module rbi_mmu_acl_cache
    import rbi_acl_pkg::*;
#(
    parameter int unsigned MISS_TMO = ACL_MISS_TMO_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        regInHold,
    input  logic [35:0] tlbInAcc,
    input  logic [63:0] regInKRR,
    input  logic        ldaclValid,
    input  logic [47:0] ldaclEntry,
    input  logic        invAclAll,
    output logic [47:0] aclEntryA,
    output logic [47:0] aclEntryB,
    output logic [47:0] aclEntryC,
    output logic [47:0] aclEntryD,
    output logic        aclMissReq,
    input  logic        aclMissAck,
    output logic [15:0] aclMissId
);

    localparam logic [7:0] TmoCnt = 8'(MISS_TMO);

    acl_entry_t  slot_q [ACL_SLOTS];
    acl_entry_t  slot_d [ACL_SLOTS];
    logic [3:0]  valid_q, valid_d;

    logic [15:0] id_q, id_d;
    logic        en_q, en_d;
    logic [63:0] krr_q, krr_d;

    miss_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] miss_id_q, miss_id_d;

    logic [3:0]  hit;
    logic        hit_any;
    logic [1:0]  hit_idx;
    logic [3:0]  dup;
    logic        dup_any;
    logic [1:0]  dup_idx;
    logic        miss;

    logic        do_shift;
    logic [1:0]  shift_pos;
    acl_entry_t  head;

    logic        unused_acc;
    assign unused_acc = ^{tlbInAcc[35:32], tlbInAcc[15:6], tlbInAcc[4:0]};

    for (genvar g = 0; g < ACL_SLOTS; g++) begin : g_match
        rbi_acl_slot_match u_match (
            .valid_i  (valid_q[g]),
            .entry_i  (slot_q[g]),
            .acl_id_i (id_q),
            .krr_i    (krr_q),
            .hit_o    (hit[g])
        );
    end

    // Priority-encode the lowest matching slot and any duplicate of the insert
    always_comb begin
        hit_idx = 2'd0;
        dup_idx = 2'd0;
        for (int i = ACL_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = 2'(i);
            if (dup[i]) dup_idx = 2'(i);
        end
        hit_any = |hit;
        dup_any = |dup;
        miss    = en_q && !hit_any;
    end

    // A slot duplicating the insert's {key, ID} is pulled out rather than kept twice
    always_comb begin
        for (int i = 0; i < ACL_SLOTS; i++) begin
            dup[i] = valid_q[i] &&
                     (slot_q[i][ACL_KEY_MSB:ACL_ID_LSB] == ldaclEntry[ACL_KEY_MSB:ACL_ID_LSB]);
        end
    end

    // Lookup capture, frozen by pipeline hold
    always_comb begin
        id_d  = id_q;
        en_d  = en_q;
        krr_d = krr_q;
        if (!regInHold) begin
            id_d  = tlbInAcc[31:16];
            en_d  = tlbInAcc[5];
            krr_d = regInKRR;
        end
    end

    // Table update: invalidate > insert > hit promotion. Insert and promotion
    // share one shift: slots 1..shift_pos take their upper neighbour, head goes to A.
    always_comb begin
        do_shift  = 1'b0;
        shift_pos = 2'd3;
        head      = ldaclEntry;
        if (!invAclAll && ldaclValid) begin
            do_shift  = 1'b1;
            shift_pos = dup_any ? dup_idx : 2'd3;
        end
`ifdef RBI_ACL_HITPROMOTE_EN
        else if (!invAclAll && !regInHold && hit_any && (hit_idx != 2'd0)) begin
            do_shift  = 1'b1;
            shift_pos = hit_idx;
            head      = slot_q[hit_idx];
        end
`endif

        slot_d  = slot_q;
        valid_d = valid_q;
        if (invAclAll) begin
            valid_d = 4'b0000;
            if (ldaclValid) begin
                slot_d[0]  = ldaclEntry;
                valid_d[0] = 1'b1;
            end
        end else if (do_shift) begin
            for (int i = 1; i < ACL_SLOTS; i++) begin
                if (i <= int'(shift_pos)) begin
                    slot_d[i]  = slot_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end
            slot_d[0]  = head;
            valid_d[0] = 1'b1;
        end
    end

    // Miss request FSM next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        miss_id_d = miss_id_q;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    miss_id_d = id_q;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (aclMissAck) begin
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (ldaclValid || invAclAll || (cnt_q == TmoCnt)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q    <= '{default: '0};
            valid_q   <= 4'b0000;
            id_q      <= 16'h0;
            en_q      <= 1'b0;
            krr_q     <= 64'h0;
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            miss_id_q <= 16'h0;
        end else begin
            slot_q    <= slot_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            en_q      <= en_d;
            krr_q     <= krr_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            miss_id_q <= miss_id_d;
        end
    end

    assign aclEntryA  = valid_q[0] ? slot_q[0] : '0;
    assign aclEntryB  = valid_q[1] ? slot_q[1] : '0;
    assign aclEntryC  = valid_q[2] ? slot_q[2] : '0;
    assign aclEntryD  = valid_q[3] ? slot_q[3] : '0;
    assign aclMissReq = (state_q == StReq);
    assign aclMissId  = miss_id_q;

endmodule

// File: tb/tb_rbi_mmu_acl_cache.sv
// Self-checking bench for rbi_mmu_acl_cache: directed scenarios followed by
// random traffic, all compared every cycle against a queue-based reference.
module tb_rbi_mmu_acl_cache;

    localparam int unsigned TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        regInHold;
    logic [35:0] tlbInAcc;
    logic [63:0] regInKRR;
    logic        ldaclValid;
    logic [47:0] ldaclEntry;
    logic        invAclAll;
    logic [47:0] aclEntryA, aclEntryB, aclEntryC, aclEntryD;
    logic        aclMissReq;
    logic        aclMissAck;
    logic [15:0] aclMissId;

    always #5 clock = ~clock;

    rbi_mmu_acl_cache #(.MISS_TMO(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .regInHold  (regInHold),
        .tlbInAcc   (tlbInAcc),
        .regInKRR   (regInKRR),
        .ldaclValid (ldaclValid),
        .ldaclEntry (ldaclEntry),
        .invAclAll  (invAclAll),
        .aclEntryA  (aclEntryA),
        .aclEntryB  (aclEntryB),
        .aclEntryC  (aclEntryC),
        .aclEntryD  (aclEntryD),
        .aclMissReq (aclMissReq),
        .aclMissAck (aclMissAck),
        .aclMissId  (aclMissId)
    );

    // Reference: MRU-ordered list of valid entries plus miss bookkeeping
    logic [47:0] mq[$];
    logic [15:0] m_id;
    logic        m_en;
    logic [63:0] m_krr;
    int          m_phase;   // 0 no miss, 1 requesting, 2 awaiting fill
    int          m_waited;
    logic [15:0] m_mid;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] keyset [4] = '{16'h0000, 16'h1234, 16'h5678, 16'hABCD};

    function automatic logic [47:0] mk(input logic [15:0] id, input logic [15:0] key,
                                       input logic [11:0] mode);
        return {4'h0, mode, key, id};
    endfunction

    function automatic bit m_match(input logic [47:0] e, input logic [15:0] id,
                                   input logic [63:0] krr);
        logic [15:0] key;
        for (int k = 0; k < 4; k++) begin
            key = krr[16*k +: 16];
            if (key != 16'h0 && key == e[31:16] && e[15:0] == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_id     = 16'h0;
        m_en     = 1'b0;
        m_krr    = 64'h0;
        m_phase  = 0;
        m_waited = 0;
        m_mid    = 16'h0;
    endtask

    task automatic model_step();
        int          h;
        bit          miss;
        logic [47:0] e;
        if (reset) begin
            model_reset();
            return;
        end
        h = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (h < 0 && m_match(mq[i], m_id, m_krr)) h = i;
        end
        miss = m_en && (h < 0);

        if (invAclAll) begin
            mq.delete();
            if (ldaclValid) mq.push_front(ldaclEntry);
        end else if (ldaclValid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i][31:0] == ldaclEntry[31:0]) begin
                    mq.delete(i);
                    break;
                end
            end
            mq.push_front(ldaclEntry);
            if (mq.size() > 4) void'(mq.pop_back());
        end
`ifdef RBI_ACL_HITPROMOTE_EN
        else if (!regInHold && h > 0) begin
            e = mq[h];
            mq.delete(h);
            mq.push_front(e);
        end
`endif

        if (m_phase == 0) begin
            if (miss) begin
                m_phase = 1;
                m_mid   = m_id;
            end
        end else if (m_phase == 1) begin
            if (aclMissAck) begin
                m_phase  = 2;
                m_waited = 0;
            end
        end else begin
            m_waited++;
            if (ldaclValid || invAclAll || m_waited > int'(TMO)) m_phase = 0;
        end

        if (!regInHold) begin
            m_id  = tlbInAcc[31:16];
            m_en  = tlbInAcc[5];
            m_krr = regInKRR;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] m_slot(input int k);
        return (k < mq.size()) ? mq[k] : 48'h0;
    endfunction

    task automatic check_all();
        chk("entryA", {16'h0, aclEntryA}, {16'h0, m_slot(0)});
        chk("entryB", {16'h0, aclEntryB}, {16'h0, m_slot(1)});
        chk("entryC", {16'h0, aclEntryC}, {16'h0, m_slot(2)});
        chk("entryD", {16'h0, aclEntryD}, {16'h0, m_slot(3)});
        chk("missReq", {63'h0, aclMissReq}, {63'h0, (m_phase == 1)});
        chk("missId", {48'h0, aclMissId}, {48'h0, m_mid});
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic insert(input logic [47:0] e);
        ldaclEntry = e;
        ldaclValid = 1'b1;
        cycle();
        ldaclValid = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] id, input logic en);
        tlbInAcc = {4'h0, id, 10'h0, en, 5'h0};
    endtask

    initial begin
        reset      = 1'b1;
        regInHold  = 1'b0;
        tlbInAcc   = 36'h0;
        regInKRR   = 64'h0;
        ldaclValid = 1'b0;
        ldaclEntry = 48'h0;
        invAclAll  = 1'b0;
        aclMissAck = 1'b0;
        model_reset();

        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("rstA", {16'h0, aclEntryA}, 64'h0);
        chk("rstReq", {63'h0, aclMissReq}, 64'h0);

        // Three inserts land in reverse order
        regInKRR = {48'h0, 16'h1234};
        insert(mk(16'h0011, 16'h1234, 12'h0A5));
        insert(mk(16'h0022, 16'h1234, 12'h0A5));
        insert(mk(16'h0033, 16'h1234, 12'h0A5));
        chk("ins3A", {16'h0, aclEntryA}, {16'h0, mk(16'h0033, 16'h1234, 12'h0A5)});
        chk("ins3C", {16'h0, aclEntryC}, {16'h0, mk(16'h0011, 16'h1234, 12'h0A5)});
        chk("ins3D", {16'h0, aclEntryD}, 64'h0);

        // Hit on the oldest entry
        lookup(16'h0011, 1'b1);
        cycle();
        cycle();
`ifdef RBI_ACL_HITPROMOTE_EN
        chk("promA", {16'h0, aclEntryA}, {16'h0, mk(16'h0011, 16'h1234, 12'h0A5)});
        chk("promB", {16'h0, aclEntryB}, {16'h0, mk(16'h0033, 16'h1234, 12'h0A5)});
`else
        chk("fifoA", {16'h0, aclEntryA}, {16'h0, mk(16'h0033, 16'h1234, 12'h0A5)});
        chk("fifoC", {16'h0, aclEntryC}, {16'h0, mk(16'h0011, 16'h1234, 12'h0A5)});
`endif
        lookup(16'h0000, 1'b0);
        cycle();
        cycle();

        // Miss, ack, fill
        lookup(16'h0044, 1'b1);
        cycle();
        cycle();
        chk("missReqHi", {63'h0, aclMissReq}, 64'h1);
        chk("missId44", {48'h0, aclMissId}, 64'h44);
        lookup(16'h0000, 1'b0);
        aclMissAck = 1'b1;
        cycle();
        aclMissAck = 1'b0;
        chk("ackDrop", {63'h0, aclMissReq}, 64'h0);
        cycle();
        insert(mk(16'h0044, 16'h1234, 12'h111));
        chk("fillA", {16'h0, aclEntryA}, {16'h0, mk(16'h0044, 16'h1234, 12'h111)});
        cycle();

        // Overflow drops the oldest
        invAclAll = 1'b1;
        cycle();
        invAclAll = 1'b0;
        for (int i = 1; i <= 5; i++) insert(mk(16'h0060 + 16'(i), 16'h1234, 12'h222));
        chk("ovfA", {16'h0, aclEntryA}, {16'h0, mk(16'h0065, 16'h1234, 12'h222)});
        chk("ovfD", {16'h0, aclEntryD}, {16'h0, mk(16'h0062, 16'h1234, 12'h222)});

        // Timeout: a miss still present after WAIT is sampled again exactly on exit
        lookup(16'h0099, 1'b1);
        cycle();
        cycle();
        chk("tmoReq", {63'h0, aclMissReq}, 64'h1);
        aclMissAck = 1'b1;
        cycle();
        aclMissAck = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        lookup(16'h0000, 1'b0);
        aclMissAck = 1'b1;
        cycle();
        aclMissAck = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("tmoIdle", {63'h0, aclMissReq}, 64'h0);

        // Invalidate + insert together
        invAclAll  = 1'b1;
        insert(mk(16'h0055, 16'h1234, 12'h333));
        invAclAll  = 1'b0;
        chk("invInsA", {16'h0, aclEntryA}, {16'h0, mk(16'h0055, 16'h1234, 12'h333)});
        chk("invInsB", {16'h0, aclEntryB}, 64'h0);

        // Re-insert of an existing {ID, key} moves it without duplicating
        insert(mk(16'h0066, 16'h1234, 12'h333));
        insert(mk(16'h0077, 16'h1234, 12'h333));
        insert(mk(16'h0055, 16'h1234, 12'h444));
        chk("reinsA", {16'h0, aclEntryA}, {16'h0, mk(16'h0055, 16'h1234, 12'h444)});
        chk("reinsB", {16'h0, aclEntryB}, {16'h0, mk(16'h0077, 16'h1234, 12'h333)});
        chk("reinsD", {16'h0, aclEntryD}, 64'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 499) == 0);
            regInHold  = ($urandom_range(0, 3) == 0);
            invAclAll  = ($urandom_range(0, 39) == 0);
            ldaclValid = ($urandom_range(0, 3) == 0);
            ldaclEntry = mk(16'h0010 + 16'($urandom_range(0, 5)),
                            keyset[$urandom_range(1, 3)], 12'($urandom));
            aclMissAck = ($urandom_range(0, 2) == 0);
            lookup(16'h0010 + 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 4; k++) regInKRR[16*k +: 16] = keyset[$urandom_range(0, 3)];
            cycle();
        end

        reset      = 1'b0;
        ldaclValid = 1'b0;
        invAclAll  = 1'b0;
        aclMissAck = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
